// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised vending controller accumulating 5/10-unit coins, timed dispense/refund.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC quiet cycles in COLLECT.
module vend_ctrl_param #(
    parameter int PRICE       = 15,
    parameter int CREDIT_W    = 8,
    parameter int HOLD_CYCLES = 250_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                have_coin5,
    input  logic                have_coin10,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] price,
    output logic [CREDIT_W-1:0] change,
    output logic                open,
    output logic                refund,
    output logic                coin_reject
);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [CREDIT_W-1:0] P = CREDIT_W'(PRICE);

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, REFUND} state_t;

    if (PRICE + 15 >= (1 << CREDIT_W) || PRICE < 5 || PRICE % 5 != 0) begin : g_price_chk
        $error("vend_ctrl_param: bad PRICE/CREDIT_W");
    end
    if (HOLD_CYCLES < 2 || TIMEOUT_CYC < 2) begin : g_cyc_chk
        $error("vend_ctrl_param: HOLD_CYCLES and TIMEOUT_CYC must be >= 2");
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, change_q, change_d, add, nxt;
    logic [HW-1:0]       hold_q, hold_d;
    logic                open_q, open_d, refund_q, refund_d, rej_q, rej_d;
    logic                busy, done, tmo, go_refund;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tcnt_q, tcnt_d;
    assign tmo    = state_q == COLLECT && add == '0 && tcnt_q == TW'(TIMEOUT_CYC - 1);
    assign tcnt_d = (state_q == COLLECT && state_d == COLLECT && add == '0) ? tcnt_q + TW'(1) : '0;
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) tcnt_q <= '0;
        else tcnt_q <= tcnt_d;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            change_q <= '0;
            open_q   <= 1'b0;
            refund_q <= 1'b0;
            rej_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            open_q   <= open_d;
            refund_q <= refund_d;
            rej_q    <= rej_d;
            hold_q   <= hold_d;
        end
    end

    // Coins are credited before cancel is considered, so reaching the price beats a refund.
    always_comb begin
        add       = (have_coin5 ? CREDIT_W'(5) : '0) + (have_coin10 ? CREDIT_W'(10) : '0);
        nxt       = credit_q + add;
        busy      = state_q == DISPENSE || state_q == REFUND;
        done      = hold_q == HW'(HOLD_CYCLES - 1);
        go_refund = (cancel && nxt != '0) || tmo;
        state_d   = busy ? (done ? IDLE : state_q) :
                    nxt >= P ? DISPENSE :
                    go_refund ? REFUND :
                    nxt == '0 ? IDLE : COLLECT;
    end

    always_comb begin
        credit_d = busy ? (done ? '0 : credit_q) : nxt;
        change_d = busy ? (done ? '0 : change_q) :
                   state_d == DISPENSE ? nxt - P :
                   state_d == REFUND ? nxt : '0;
        open_d   = state_d == DISPENSE;
        refund_d = state_d == REFUND;
        rej_d    = busy && (have_coin5 || have_coin10);
        hold_d   = (busy && !done) ? hold_q + HW'(1) : '0;
    end

    assign credit      = credit_q;
    assign price       = P;
    assign change      = change_q;
    assign open        = open_q;
    assign refund      = refund_q;
    assign coin_reject = rej_q;
endmodule
